// File: rtl/alu.sv
// 64-bit Y86 execute-stage ALU: ADD/SUB/AND/XOR with signed-overflow flag.
// One-cycle registered latency, accepts a new op every cycle, never stalls.
module alu (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  control,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] ansfinal,
  output logic        overflowfinal
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  op_e         op;
  logic        is_sub;
  logic [63:0] b_op;
  logic [63:0] sum;
  logic [63:0] ans_d, ans_q;
  logic        ov_d, ov_q;

  assign op     = op_e'(control);
  assign is_sub = (op == OP_SUB);

  // Single shared adder: subtraction is a + ~b + 1; carry out of bit 63 is dropped.
  assign b_op = is_sub ? ~b : b;
  assign sum  = a + b_op + {63'd0, is_sub};

  always_comb begin
    ans_d = 64'd0;
    ov_d  = 1'b0;
    case (op)
      OP_ADD: begin
        ans_d = sum;
        ov_d  = (a[63] == b[63]) && (sum[63] != a[63]);
      end
      OP_SUB: begin
        ans_d = sum;
        ov_d  = (a[63] != b[63]) && (sum[63] != a[63]);
      end
      OP_AND:  ans_d = a & b;
      OP_XOR:  ans_d = a ^ b;
      default: ans_d = 64'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ans_q <= 64'd0;
      ov_q  <= 1'b0;
    end else begin
      ans_q <= ans_d;
      ov_q  <= ov_d;
    end
  end

  assign ansfinal      = ans_q;
  assign overflowfinal = ov_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations queued at drive time, compared one edge later.
module tb_alu;

  logic        clk;
  logic        reset;
  logic [1:0]  control;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] ansfinal;
  logic        overflowfinal;

  typedef struct {
    logic [63:0] r;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  alu dut (
    .clk           (clk),
    .reset         (reset),
    .control       (control),
    .a             (a),
    .b             (b),
    .ansfinal      (ansfinal),
    .overflowfinal (overflowfinal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Reference model uses 65-bit sign-extended arithmetic; overflow when the
  // true result does not fit in 64 signed bits.
  function automatic exp_t model(input logic rst, input logic [1:0] op,
                                 input logic [63:0] x, input logic [63:0] y);
    exp_t        e;
    logic [64:0] w;
    e.r  = 64'd0;
    e.ov = 1'b0;
    w    = 65'd0;
    if (!rst) begin
      case (op)
        2'b00: begin
          w    = {x[63], x} + {y[63], y};
          e.r  = w[63:0];
          e.ov = w[64] ^ w[63];
        end
        2'b01: begin
          w    = {x[63], x} - {y[63], y};
          e.r  = w[63:0];
          e.ov = w[64] ^ w[63];
        end
        2'b10:   e.r = x & y;
        default: e.r = x ^ y;
      endcase
    end
    return e;
  endfunction

  task automatic drive(input logic rst, input logic [1:0] op,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] er, input logic eov);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    control = op;
    a       = x;
    b       = y;
    e.r     = er;
    e.ov    = eov;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 2'b00, 64'd5, 64'd3, 64'd0, 1'b0);
      else       drive(1'b0, 2'b00, 64'd5, 64'd3, 64'd8, 1'b0);
      e = sb.pop_front();
      total++;
      if (ansfinal !== e.r) $display("FAIL reset[%0d] ans got %h want %h", i, ansfinal, e.r);
      else passed++;
      total++;
      if (overflowfinal !== e.ov) $display("FAIL reset[%0d] ov got %b want %b", i, overflowfinal, e.ov);
      else passed++;
    end
  endtask

  task automatic test_positive();
    exp_t e;
    logic [63:0] want [4] = '{64'd15, 64'd7, 64'd0, 64'd15};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'(i), 64'd11, 64'd4, want[i], 1'b0);
      e = sb.pop_front();
      total++;
      if (ansfinal !== e.r) $display("FAIL positive op%0d ans got %h want %h", i, ansfinal, e.r);
      else passed++;
      total++;
      if (overflowfinal !== e.ov) $display("FAIL positive op%0d ov got %b want %b", i, overflowfinal, e.ov);
      else passed++;
    end
  endtask

  task automatic test_negative();
    exp_t e;
    logic [63:0] want [3] = '{-64'sd7, -64'sd15, 64'd4};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'(i), -64'sd11, 64'd4, want[i], 1'b0);
      e = sb.pop_front();
      total++;
      if (ansfinal !== e.r) $display("FAIL negative op%0d ans got %h want %h", i, ansfinal, e.r);
      else passed++;
      total++;
      if (overflowfinal !== e.ov) $display("FAIL negative op%0d ov got %b want %b", i, overflowfinal, e.ov);
      else passed++;
    end
  endtask

  // Rows: op, a, b, expected result, expected overflow.
  task automatic test_boundaries();
    exp_t e;
    logic [1:0]  op  [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00};
    logic [63:0] xa  [6] = '{64'd2147483647, 64'd2147483647, 64'h7FFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000, 64'd0, 64'd0};
    logic [63:0] xb  [6] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1,
                             64'h8000_0000_0000_0000, 64'd0};
    logic [63:0] wr  [6] = '{64'd2147483648, 64'd2147483648, 64'h8000_0000_0000_0000,
                             64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0};
    logic        wov [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, op[i], xa[i], xb[i], wr[i], wov[i]);
      e = sb.pop_front();
      total++;
      if (ansfinal !== e.r) $display("FAIL boundary[%0d] ans got %h want %h", i, ansfinal, e.r);
      else passed++;
      total++;
      if (overflowfinal !== e.ov) $display("FAIL boundary[%0d] ov got %b want %b", i, overflowfinal, e.ov);
      else passed++;
    end
  endtask

  // Random ops on consecutive edges with a reset pulse mid-stream; also checks
  // that outputs hold until the next edge.
  task automatic test_back_to_back();
    exp_t        e, m;
    logic        rst;
    logic [1:0]  op;
    logic [63:0] x, y;
    for (int i = 0; i < 40; i++) begin
      rst = (i == 17) || (i == 18);
      op  = 2'($urandom_range(0, 3));
      x   = {$urandom, $urandom};
      y   = {$urandom, $urandom};
      if (i % 5 == 0) y = x;
      if (i % 7 == 0) x = {1'b0, {63{1'b1}}};
      m = model(rst, op, x, y);
      drive(rst, op, x, y, m.r, m.ov);
      e = sb.pop_front();
      total++;
      if (ansfinal !== e.r) $display("FAIL b2b[%0d] ans got %h want %h", i, ansfinal, e.r);
      else passed++;
      total++;
      if (overflowfinal !== e.ov) $display("FAIL b2b[%0d] ov got %b want %b", i, overflowfinal, e.ov);
      else passed++;
      if (i % 8 == 3) begin
        a = ~a;
        b = ~b;
        @(negedge clk);
        total++;
        if (ansfinal !== e.r || overflowfinal !== e.ov)
          $display("FAIL hold[%0d] got %h/%b want %h/%b", i, ansfinal, overflowfinal, e.r, e.ov);
        else passed++;
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    control = 2'b00;
    a       = 64'd0;
    b       = 64'd0;
    test_reset();
    test_positive();
    test_negative();
    test_boundaries();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
